// File: rtl/conv3x3_mf_engine.sv
// Streaming 3x3 valid-convolution engine: NF filters in parallel on one channel,
// runtime weights, stride-1/stride-2 window selection and optional ReLU.
module conv3x3_mf_engine #(
  parameter int M      = 8,
  parameter int IMG_W  = 482,
  parameter int IMG_H  = 482,
  parameter int NF     = 2,
  localparam int AW    = 2*M+4,
  localparam int NW    = NF*9,
  localparam int WA    = $clog2(NF*9)
) (
  input  logic             clk,
  input  logic             Rst_n,
  input  logic [M-1:0]     din,
  input  logic             valid_in,
  input  logic             w_we,
  input  logic [WA-1:0]    w_addr,
  input  logic [M-1:0]     w_data,
  input  logic             relu_en,
  input  logic             stride2,
  output logic [NF*AW-1:0] dout,
  output logic             valid_out,
  output logic             busy,
  output logic             frame_done
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0] X_MAX = XW'(IMG_W-1);
  localparam logic [YW-1:0] Y_MAX = YW'(IMG_H-1);
  // With stride 2 only even x/y windows are emitted, so the last one sits on the largest even coordinate.
  localparam logic [XW-1:0] X_LAST2 = (IMG_W % 2 == 1) ? XW'(IMG_W-1) : XW'(IMG_W-2);
  localparam logic [YW-1:0] Y_LAST2 = (IMG_H % 2 == 1) ? YW'(IMG_H-1) : YW'(IMG_H-2);

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic stride_r, relu_r;
  logic signed [M-1:0] lb0 [IMG_W];
  logic signed [M-1:0] lb1 [IMG_W];
  logic signed [M-1:0] win [9];
  logic signed [M-1:0] wt [NW];
  logic signed [2*M-1:0] prod [NF][9];
  logic signed [AW-1:0] sum_c [NF];
  logic signed [AW-1:0] sum_r [NF];
  logic v0, v1, v2;
  logic rl0, rl1, rl2;
  logic ls0, ls1, ls2;
  logic first_px, win_ok, last_win, w_ok;

  always_comb begin
    first_px = (x == '0) && (y == '0);
    win_ok   = (x >= XW'(2)) && (y >= YW'(2)) && (!stride_r || (!x[0] && !y[0]));
    last_win = stride_r ? ((x == X_LAST2) && (y == Y_LAST2)) : ((x == X_MAX) && (y == Y_MAX));
    // A write landing together with a pixel would corrupt the frame being started, so it is refused too.
    w_ok     = w_we && !valid_in && !busy && !v0 && !v1 && !v2 && (w_addr < WA'(NW));
  end

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      x        <= '0;
      y        <= '0;
      busy     <= 1'b0;
      stride_r <= 1'b0;
      relu_r   <= 1'b0;
    end else begin
      if (valid_in) begin
        if (first_px) begin
          stride_r <= stride2;
          relu_r   <= relu_en;
        end
        if (x == X_MAX) begin
          x <= '0;
          y <= (y == Y_MAX) ? '0 : y + YW'(1);
        end else begin
          x <= x + XW'(1);
        end
      end
      if (valid_in && first_px)
        busy <= 1'b1;
      else if (v2 && ls2)
        busy <= 1'b0;
    end
  end

  // Two row buffers feed the right-hand column of the 3x3 window; older columns shift left.
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < IMG_W; i++) begin
        lb0[i] <= '0;
        lb1[i] <= '0;
      end
      for (int t = 0; t < 9; t++) win[t] <= '0;
    end else if (valid_in) begin
      lb0[x] <= $signed(din);
      lb1[x] <= lb0[x];
      for (int r = 0; r < 3; r++) begin
        win[3*r]   <= win[3*r+1];
        win[3*r+1] <= win[3*r+2];
      end
      win[2] <= lb1[x];
      win[5] <= lb0[x];
      win[8] <= $signed(din);
    end
  end

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < NW; i++) wt[i] <= '0;
    end else if (w_ok) begin
      wt[w_addr] <= $signed(w_data);
    end
  end

  always_comb begin
    for (int f = 0; f < NF; f++) begin
      sum_c[f] = '0;
      for (int t = 0; t < 9; t++) sum_c[f] = sum_c[f] + AW'(prod[f][t]);
    end
  end

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      {v0, v1, v2}    <= '0;
      {rl0, rl1, rl2} <= '0;
      {ls0, ls1, ls2} <= '0;
      for (int f = 0; f < NF; f++) begin
        sum_r[f] <= '0;
        for (int t = 0; t < 9; t++) prod[f][t] <= '0;
      end
    end else begin
      v0  <= valid_in && win_ok;
      rl0 <= relu_r;
      ls0 <= last_win;
      v1  <= v0;
      rl1 <= rl0;
      ls1 <= ls0;
      v2  <= v1;
      rl2 <= rl1;
      ls2 <= ls1;
      for (int f = 0; f < NF; f++) begin
        for (int t = 0; t < 9; t++) prod[f][t] <= win[t] * wt[f*9+t];
        sum_r[f] <= sum_c[f];
      end
    end
  end

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      dout       <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      valid_out  <= v2;
      frame_done <= v2 && ls2;
      if (v2) begin
        for (int f = 0; f < NF; f++)
          dout[f*AW +: AW] <= (rl2 && sum_r[f][AW-1]) ? '0 : sum_r[f];
      end
    end
  end

endmodule

// File: doc/conv3x3_mf_engine.md
Name: conv3x3_mf_engine

Overview:
- Parametrised successor to the single-pair 3x3 convolution top: one streaming 3x3 valid-convolution engine with NF filters evaluated in parallel on one feature-map channel.
- Integrates line buffering, a runtime weight register file, a pipelined signed multiply/adder tree, and selectable stride-1/stride-2 and ReLU modes.
- Sits between the feature-map stream source and the output/partial-sum collector of the accelerator.

Parameters:
- M, 8, signed pixel and weight width.
- IMG_W, 482, feature-map width in pixels (padding already applied upstream); minimum 3.
- IMG_H, 482, feature-map height in rows; minimum 3.
- NF, 2, number of filters computed in parallel.
- AW (localparam), 2*M+4, accumulator/output width per filter.

Ports:
- clk, input, 1, clock.
- Rst_n, input, 1, asynchronous active-low reset.
- din, input, M, signed pixel, raster order.
- valid_in, input, 1, din is valid this cycle; gaps allowed.
- w_we, input, 1, weight write strobe.
- w_addr, input, clog2(NF*9), weight index = f*9 + tap, where tap = 3*row + col of the window, top-left is 0.
- w_data, input, M, signed weight.
- relu_en, input, 1, clamp negative results to 0.
- stride2, input, 1, 0 = stride 1, 1 = stride 2; sampled at the first pixel of a frame.
- dout, output, NF*AW, filter f occupies bits [f*AW +: AW]; signed.
- valid_out, output, 1, dout is valid.
- busy, output, 1, a frame is in progress.
- frame_done, output, 1, one-cycle pulse with the last valid_out of the frame.

Behaviour:
- Reset: dout=0, valid_out=0, busy=0, frame_done=0; x/y counters, line buffers and pipeline valids clear; weights clear to 0.
- Pixel counters x (0..IMG_W-1) and y (0..IMG_H-1) advance only on valid_in. x wraps to 0 and increments y. After the last pixel (IMG_W-1, IMG_H-1), both return to 0.
- busy: set on the first accepted pixel of a frame; cleared in the cycle frame_done pulses.
- stride2 and relu_en are latched into frame registers when the pixel at (0,0) is accepted; changes mid-frame have no effect.
- Line buffers: two IMG_W-deep rows plus a 3x3 shift window. The window holds rows y-2..y and columns x-2..x of the pixel just accepted.
- Window valid: x>=2 and y>=2. With stride2, additionally (x-2) and (y-2) must both be even.
- Output count per frame: (IMG_W-2)*(IMG_H-2) at stride 1; ceil((IMG_W-2)/2)*ceil((IMG_H-2)/2) at stride 2.
- Pipeline, fixed latency 3 cycles from the accepting clock edge to valid_out=1; advances every cycle regardless of valid_in gaps.
  - Stage 1: 9*NF signed M x M products, each 2M bits.
  - Stage 2: 9-term sign-extended sum to AW bits. No overflow is possible.
  - Stage 3: optional ReLU, then register to dout.
- valid_out is high exactly one cycle per valid window. dout holds its last value when valid_out=0.
- frame_done coincides with the valid_out of the last window: (IMG_W-1, IMG_H-1) at stride 1, or the last even-aligned window at stride 2.
- Weight writes:
  - Accepted only when busy=0 and the pipeline is empty. Otherwise w_we is ignored.
  - A write takes effect for the next frame.
  - w_addr >= NF*9 is ignored.
- Simultaneous last pixel and w_we: the write is ignored, because busy is still 1.
- Reset mid-frame: all state returns to reset values immediately. The next accepted pixel is treated as (0,0).

Test Plan:
- Frame 1 setup: IMG_W=IMG_H=5, M=8, NF=2, stride 1, ReLU off. Filter0 all taps = 1; filter1 tap4 = -1, others 0. Stream pixels 0..24 continuously.
  - Required: 9 valid_out pulses, each 3 cycles after its window pixel.
  - First output: f0=54, f1=-6.
  - Last output: f0=162, f1=-18, with frame_done on the same cycle.
- Repeat frame 1 with relu_en=1 -> f1=0 for all 9 outputs; f0 values unchanged.
- Repeat frame 1 with stride2=1 -> exactly 4 outputs; f0 = 54, 72, 144, 162; frame_done on the 4th.
- Random valid_in gaps (about 50% duty) on the same frame -> identical dout sequence and count as the continuous case.
- w_we to filter0 tap0 = 5 while busy=1 -> ignored; the current frame is unchanged.
  - The same write after frame_done is accepted -> next frame's first f0 = 54 + 4*0 = 54, because pixel 0 is 0.
  - Check with a ramp starting at 1 (pixels 1..25): first f0 = 63 + 4*1 = 67.
- Assert Rst_n low after 12 pixels -> valid_out, busy and dout go to 0 at once. A fresh full frame after release gives the same 9 results as the first test, except weights are now 0, so all outputs are 0.
